// File: rtl/fsm_pkg.sv
// Shared types and limits for the rd/ws/ds read-handshake responder.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    ARM    = 2'd2
  } resp_state_t;

  localparam int WAIT_MAX = 15;
  localparam int WAIT_W   = 4;

endpackage

// File: rtl/rd_resp_fifo.sv
// Synchronous word FIFO feeding the read responder; pointers wrap modulo DEPTH.
module rd_resp_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_wdata,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == LW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is not reset; a cleared count makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fsm_read_responder.sv
// Target-side responder: answers each initiator DLY sample with a registered ws,
// releasing one FIFO word on rdata once the wait count expires and data exists.
module fsm_read_responder
  import fsm_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int WAIT_N = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd,
  output logic                       ws,
  output logic [DW-1:0]              rdata,
  input  logic                       wvalid,
  input  logic [DW-1:0]              wdata,
  output logic                       wready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       proto_err
);

  localparam int                LW        = $clog2(DEPTH+1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_N);

  resp_state_t       r_state, w_state_nxt;
  logic              r_ws, w_ws_nxt;
  logic [DW-1:0]     r_rdata, w_rdata_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_cnt_nxt, w_cnt_eval;
  logic              r_proto_err, w_err_nxt;
  logic              w_eval, w_release, w_pop;
  logic              w_full, w_empty;
  logic [DW-1:0]     w_head;
  logic [LW-1:0]     w_count;

  rd_resp_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wvalid),
    .i_wdata (wdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign wready    = !w_full;
  assign level     = w_count;
  assign ws        = r_ws;
  assign rdata     = r_rdata;
  assign proto_err = r_proto_err;

  // The first READ cycle evaluates against a freshly loaded WAIT_N count.
  assign w_cnt_eval = (r_state == IDLE) ? WAIT_INIT : r_wait_cnt;
  assign w_release  = (w_cnt_eval == '0) && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_ws_nxt    = r_ws;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_wait_cnt;
    w_err_nxt   = r_proto_err;
    w_pop       = 1'b0;
    w_eval      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ws_nxt = 1'b1;
        if (rd) begin
          w_eval      = 1'b1;
          w_state_nxt = SAMPLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SAMPLE: begin
        if (!rd) begin
          w_err_nxt   = 1'b1;
          w_ws_nxt    = 1'b1;
          w_state_nxt = IDLE;
        end else if (!r_ws) begin
          w_pop       = 1'b1;
          w_ws_nxt    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        if (!rd) begin
          w_err_nxt   = 1'b1;
          w_ws_nxt    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_eval      = 1'b1;
          w_state_nxt = SAMPLE;
        end
      end
      default: begin
        w_ws_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
    if (w_eval) begin
      if (w_release) begin
        w_ws_nxt    = 1'b0;
        w_rdata_nxt = w_head;
        w_cnt_nxt   = w_cnt_eval;
      end else begin
        w_ws_nxt  = 1'b1;
        w_cnt_nxt = (w_cnt_eval != '0) ? (w_cnt_eval - WAIT_W'(1)) : '0;
      end
    end else begin
      w_cnt_nxt = w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ws        <= 1'b1;
      r_rdata     <= '0;
      r_wait_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ws        <= w_ws_nxt;
      r_rdata     <= w_rdata_nxt;
      r_wait_cnt  <= w_cnt_nxt;
      r_proto_err <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_read_responder.sv
// Directed bench: emulates the rd/ws initiator against WAIT_N=0 and WAIT_N=2 responders.
module tb_fsm_read_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd0 = 1'b0, wvalid0 = 1'b0, ws0, wready0, perr0;
  logic [7:0] wdata0 = 8'h00, rdata0;
  logic [2:0] level0;
  logic       rd2 = 1'b0, wvalid2 = 1'b0, ws2, wready2, perr2;
  logic [7:0] wdata2 = 8'h00, rdata2;
  logic [2:0] level2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fsm_read_responder #(.DW(8), .DEPTH(4), .WAIT_N(0)) dut0 (
    .clk(clk), .rst(rst), .rd(rd0), .ws(ws0), .rdata(rdata0), .wvalid(wvalid0),
    .wdata(wdata0), .wready(wready0), .level(level0), .proto_err(perr0)
  );

  fsm_read_responder #(.DW(8), .DEPTH(4), .WAIT_N(2)) dut2 (
    .clk(clk), .rst(rst), .rd(rd2), .ws(ws2), .rdata(rdata2), .wvalid(wvalid2),
    .wdata(wdata2), .wready(wready2), .level(level2), .proto_err(perr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sel, input logic [7:0] d);
    if (sel) begin wvalid2 = 1'b1; wdata2 = d; end
    else begin wvalid0 = 1'b1; wdata0 = d; end
    tick();
    wvalid0 = 1'b0;
    wvalid2 = 1'b0;
  endtask

  // One initiator transaction: READ then DLY per loop, ws sampled in each DLY cycle.
  task automatic do_read(input bit sel, output logic [7:0] data, output int n,
                         output logic [7:0] hist);
    bit   done = 1'b0;
    logic w;
    n = 0; hist = 8'h00; data = 8'h00;
    if (sel) rd2 = 1'b1; else rd0 = 1'b1;
    while (!done && n < 8) begin
      tick();
      n++;
      w    = sel ? ws2 : ws0;
      hist = {hist[6:0], w};
      if (!w) begin
        data = sel ? rdata2 : rdata0;
        done = 1'b1;
      end
      tick();
    end
    rd0 = 1'b0;
    rd2 = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL read_timeout: no ws=0 after %0d samples, required release", n);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++; if (ws0 !== 1'b1)     begin errors++; $display("FAIL reset_ws: got %b want 1", ws0); end
    checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata0); end
    checks++; if (level0 !== 3'd0)  begin errors++; $display("FAIL reset_level: got %0d want 0", level0); end
    checks++; if (wready0 !== 1'b1) begin errors++; $display("FAIL reset_wready: got %b want 1", wready0); end
    checks++; if (perr0 !== 1'b0)   begin errors++; $display("FAIL reset_perr: got %b want 0", perr0); end
    checks++; if (ws2 !== 1'b1)     begin errors++; $display("FAIL reset_ws2: got %b want 1", ws2); end
  endtask

  task automatic test_single_word();
    logic [7:0] d, h; int n;
    push(1'b0, 8'hA5);
    checks++; if (level0 !== 3'd1) begin errors++; $display("FAIL single_level_pre: got %0d want 1", level0); end
    do_read(1'b0, d, n, h);
    checks++; if (n !== 1)      begin errors++; $display("FAIL single_samples: got %0d want 1", n); end
    checks++; if (d !== 8'hA5)  begin errors++; $display("FAIL single_data: got %h want a5", d); end
    checks++; if (level0 !== 3'd0) begin errors++; $display("FAIL single_level_post: got %0d want 0", level0); end
    checks++; if (ws0 !== 1'b1) begin errors++; $display("FAIL single_ws_idle: got %b want 1", ws0); end
  endtask

  // Start with an empty FIFO; the producer word lands on edge push_edge.
  task automatic test_empty_start(input int push_edge, input int exp_n, input logic [7:0] wd);
    logic [7:0] d, h; int n;
    fork
      do_read(1'b0, d, n, h);
      begin
        repeat (push_edge - 1) tick();
        wvalid0 = 1'b1; wdata0 = wd;
        tick();
        wvalid0 = 1'b0;
      end
    join
    checks++; if (n !== exp_n) begin errors++; $display("FAIL empty_samples_e%0d: got %0d want %0d", push_edge, n, exp_n); end
    checks++; if (d !== wd)    begin errors++; $display("FAIL empty_data_e%0d: got %h want %h", push_edge, d, wd); end
    checks++; if (level0 !== 3'd0) begin errors++; $display("FAIL empty_level_e%0d: got %0d want 0", push_edge, level0); end
  endtask

  task automatic test_wait2();
    logic [7:0] d, h; int n;
    push(1'b1, 8'h5A);
    do_read(1'b1, d, n, h);
    checks++; if (n !== 3)         begin errors++; $display("FAIL wait2_samples: got %0d want 3", n); end
    checks++; if ((2 * n) !== 6)   begin errors++; $display("FAIL wait2_rd_cycles: got %0d want 6", 2 * n); end
    checks++; if (h !== 8'b110)    begin errors++; $display("FAIL wait2_ws_seq: got %b want 110", h[2:0]); end
    checks++; if (d !== 8'h5A)     begin errors++; $display("FAIL wait2_data: got %h want 5a", d); end
    checks++; if (level2 !== 3'd0) begin errors++; $display("FAIL wait2_level: got %0d want 0", level2); end
  endtask

  task automatic test_fill_order();
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] d, h; int n;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, words[i]);
      checks++; if (level0 !== 3'(i + 1)) begin errors++; $display("FAIL fill_level%0d: got %0d want %0d", i, level0, i + 1); end
      checks++; if (wready0 !== (i < 3))  begin errors++; $display("FAIL fill_wready%0d: got %b want %b", i, wready0, (i < 3)); end
    end
    push(1'b0, 8'h55);
    checks++; if (level0 !== 3'd4) begin errors++; $display("FAIL fill_overflow: got %0d want 4", level0); end
    for (int i = 0; i < 4; i++) begin
      do_read(1'b0, d, n, h);
      checks++; if (d !== words[i]) begin errors++; $display("FAIL fill_data%0d: got %h want %h", i, d, words[i]); end
      checks++; if (level0 !== 3'(3 - i)) begin errors++; $display("FAIL fill_drain%0d: got %0d want %0d", i, level0, 3 - i); end
      if (i == 0) begin
        checks++; if (wready0 !== 1'b1) begin errors++; $display("FAIL fill_wready_reassert: got %b want 1", wready0); end
      end
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] d, h; int n;
    push(1'b0, 8'hA1);
    push(1'b0, 8'hA2);
    fork
      do_read(1'b0, d, n, h);
      begin
        tick();
        wvalid0 = 1'b1; wdata0 = 8'hA3;
        tick();
        wvalid0 = 1'b0;
      end
    join
    checks++; if (d !== 8'hA1)     begin errors++; $display("FAIL pp_data0: got %h want a1", d); end
    checks++; if (level0 !== 3'd2) begin errors++; $display("FAIL pp_level: got %0d want 2", level0); end
    do_read(1'b0, d, n, h);
    checks++; if (d !== 8'hA2) begin errors++; $display("FAIL pp_data1: got %h want a2", d); end
    do_read(1'b0, d, n, h);
    checks++; if (d !== 8'hA3) begin errors++; $display("FAIL pp_data2: got %h want a3", d); end
  endtask

  task automatic test_protocol();
    logic [7:0] d, h; int n;
    push(1'b0, 8'h77);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    tick();
    checks++; if (perr0 !== 1'b1)  begin errors++; $display("FAIL proto_err: got %b want 1", perr0); end
    checks++; if (ws0 !== 1'b1)    begin errors++; $display("FAIL proto_ws: got %b want 1", ws0); end
    checks++; if (level0 !== 3'd1) begin errors++; $display("FAIL proto_nopop: got %0d want 1", level0); end
    do_read(1'b0, d, n, h);
    checks++; if (d !== 8'h77)    begin errors++; $display("FAIL proto_data: got %h want 77", d); end
    checks++; if (perr0 !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", perr0); end
  endtask

  task automatic test_reset_in_sample();
    push(1'b0, 8'h99);
    rd0 = 1'b1;
    tick();
    checks++; if (ws0 !== 1'b0) begin errors++; $display("FAIL rst_pre_ws: got %b want 0", ws0); end
    rst = 1'b1;
    #1;
    checks++; if (ws0 !== 1'b1)     begin errors++; $display("FAIL rst_ws: got %b want 1", ws0); end
    checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", rdata0); end
    checks++; if (level0 !== 3'd0)  begin errors++; $display("FAIL rst_level: got %0d want 0", level0); end
    checks++; if (wready0 !== 1'b1) begin errors++; $display("FAIL rst_wready: got %b want 1", wready0); end
    checks++; if (perr0 !== 1'b0)   begin errors++; $display("FAIL rst_perr: got %b want 0", perr0); end
    rd0 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_empty_start(4, 3, 8'h3C);
    test_empty_start(3, 3, 8'h4D);
    test_empty_start(2, 2, 8'h5E);
    test_wait2();
    test_fill_order();
    test_push_pop();
    test_protocol();
    test_reset_in_sample();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
